// File: rtl/load_store_unit_if.sv
//==============================================================================
// Module   : load_store_unit_if
// Brief    : Data-bus bundle between the load/store unit and its memory port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface load_store_unit_if;
  logic        o_req;
  logic        o_we;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_be;
  logic        i_ack;
  logic [31:0] i_rdata;

  modport master (
    output o_req, o_we, o_addr, o_wdata, o_be,
    input  i_ack, i_rdata
  );

  modport slave (
    input  o_req, o_we, o_addr, o_wdata, o_be,
    output i_ack, i_rdata
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
//==============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding load/store stage with byte-lane formatting.
//            Optional macro MISALIGN_TRAP_EN turns misaligned accesses into traps.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module load_store_unit (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  input  wire logic        i_ce,
  input  wire logic        i_opcode_load,
  input  wire logic        i_opcode_store,
  input  wire logic [2:0]  i_funct3,
  input  wire logic [31:0] i_addr,
  input  wire logic [31:0] i_store_data,
  input  wire logic [4:0]  i_rd_addr,
  input  wire logic        i_wr_en,
  input  wire logic [31:0] i_rd,
  output logic             o_stall,
  load_store_unit_if.master bus,
  output logic             o_ce,
  output logic [4:0]       o_rd_addr,
  output logic             o_wr_en,
  output logic [31:0]      o_rd,
  output logic [31:0]      o_mem_loaded,
  output logic             o_opcode_load,
  output logic             o_misaligned
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state;
  state_t      next_state;
  logic        mem_op;
  logic        trap_hit;
  logic        accept_alu;
  logic        accept_mem;
  logic        accept_trap;
  logic        complete;
  logic        stall;

  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        is_load_q;
  logic        wr_en_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] rd_q;

  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] shifted;
  logic [31:0] load_value;

  assign mem_op = i_opcode_load | i_opcode_store;

`ifdef MISALIGN_TRAP_EN
  assign trap_hit = (((i_funct3 == 3'b001) || (i_funct3 == 3'b101)) && i_addr[0])
                  || ((i_funct3 == 3'b010) && (i_addr[1:0] != 2'b00));
`else
  assign trap_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state  = state;
    stall       = 1'b0;
    accept_alu  = 1'b0;
    accept_mem  = 1'b0;
    accept_trap = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        if (i_ce) begin
          if (!mem_op) begin
            accept_alu = 1'b1;
          end else if (trap_hit) begin
            accept_trap = 1'b1;
          end else begin
            accept_mem = 1'b1;
            stall      = 1'b1;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.i_ack) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign o_stall = stall & i_rst_n;

  // Narrow stores are replicated across the word so the lane enables alone pick the target bytes.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        store_be    = 4'b0001 << i_addr[1:0];
        store_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        store_be    = 4'b0011 << i_addr[1:0];
        store_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = i_store_data;
      end
    endcase
  end

  always_comb begin
    shifted    = bus.i_rdata >> {offset_q, 3'b000};
    load_value = 32'd0;
    case (funct3_q)
      3'b000:  load_value = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_value = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_value = shifted;
      3'b100:  load_value = {24'd0, shifted[7:0]};
      3'b101:  load_value = {16'd0, shifted[15:0]};
      default: load_value = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bus.o_req     <= 1'b0;
      bus.o_we      <= 1'b0;
      bus.o_addr    <= 32'd0;
      bus.o_wdata   <= 32'd0;
      bus.o_be      <= 4'd0;
      o_ce          <= 1'b0;
      o_rd_addr     <= 5'd0;
      o_wr_en       <= 1'b0;
      o_rd          <= 32'd0;
      o_mem_loaded  <= 32'd0;
      o_opcode_load <= 1'b0;
      funct3_q      <= 3'd0;
      offset_q      <= 2'd0;
      is_load_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_addr_q     <= 5'd0;
      rd_q          <= 32'd0;
    end else begin
      o_ce    <= 1'b0;
      o_wr_en <= 1'b0;
      if (accept_alu) begin
        o_ce          <= 1'b1;
        o_rd_addr     <= i_rd_addr;
        o_wr_en       <= i_wr_en;
        o_rd          <= i_rd;
        o_opcode_load <= 1'b0;
      end
      if (accept_trap) begin
        o_ce          <= 1'b1;
        o_rd_addr     <= i_rd_addr;
        o_rd          <= i_rd;
        o_opcode_load <= i_opcode_load;
      end
      if (accept_mem) begin
        bus.o_req   <= 1'b1;
        bus.o_we    <= ~i_opcode_load;
        bus.o_addr  <= {i_addr[31:2], 2'b00};
        bus.o_wdata <= store_wdata;
        bus.o_be    <= i_opcode_load ? 4'b1111 : store_be;
        funct3_q    <= i_funct3;
        offset_q    <= i_addr[1:0];
        is_load_q   <= i_opcode_load;
        wr_en_q     <= i_wr_en;
        rd_addr_q   <= i_rd_addr;
        rd_q        <= i_rd;
      end
      if (complete) begin
        bus.o_req     <= 1'b0;
        o_ce          <= 1'b1;
        o_rd_addr     <= rd_addr_q;
        o_rd          <= rd_q;
        o_opcode_load <= is_load_q;
        o_wr_en       <= is_load_q & wr_en_q;
        if (is_load_q) o_mem_loaded <= load_value;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                       o_misaligned <= 1'b0;
    else if (accept_trap)               o_misaligned <= 1'b1;
    else if (accept_alu || complete)    o_misaligned <= 1'b0;
  end
`else
  assign o_misaligned = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//==============================================================================
// Module   : tb_load_store_unit
// Brief    : Randomized self-checking bench for load_store_unit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_ce;
  logic        i_opcode_load;
  logic        i_opcode_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic [4:0]  i_rd_addr;
  logic        i_wr_en;
  logic [31:0] i_rd;
  logic        o_stall;
  logic        o_ce;
  logic [4:0]  o_rd_addr;
  logic        o_wr_en;
  logic [31:0] o_rd;
  logic [31:0] o_mem_loaded;
  logic        o_opcode_load;
  logic        o_misaligned;

  int n_vec;
  int n_err;

  load_store_unit_if bus ();

  load_store_unit dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_ce          (i_ce),
    .i_opcode_load (i_opcode_load),
    .i_opcode_store(i_opcode_store),
    .i_funct3      (i_funct3),
    .i_addr        (i_addr),
    .i_store_data  (i_store_data),
    .i_rd_addr     (i_rd_addr),
    .i_wr_en       (i_wr_en),
    .i_rd          (i_rd),
    .o_stall       (o_stall),
    .bus           (bus.master),
    .o_ce          (o_ce),
    .o_rd_addr     (o_rd_addr),
    .o_wr_en       (o_wr_en),
    .o_rd          (o_rd),
    .o_mem_loaded  (o_mem_loaded),
    .o_opcode_load (o_opcode_load),
    .o_misaligned  (o_misaligned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour expressed arithmetically from the lane/format rules.
  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    int m;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (sz == 4) return 4'hF;
    m = ((1 << sz) - 1) << (a % 4);
    return 4'(m & 15);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] b;
    logic [31:0] h;
    v = rd >> (8 * (a % 4));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd2: return v;
      3'd4: return b;
      3'd5: return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    i_ce = 1'b0; i_opcode_load = 1'b0; i_opcode_store = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_alu(input logic [4:0] rda, input logic we, input logic [31:0] rdv);
    i_ce = 1'b1; i_opcode_load = 1'b0; i_opcode_store = 1'b0;
    i_rd_addr = rda; i_wr_en = we; i_rd = rdv;
    i_funct3 = 3'($urandom); i_addr = $urandom;
    #1;
    check("alu_stall", 32'(o_stall), 32'd0);
    next_cycle();
    idle_inputs();
    check("alu_ce", 32'(o_ce), 32'd1);
    check("alu_rd", o_rd, rdv);
    check("alu_rd_addr", 32'(o_rd_addr), 32'(rda));
    check("alu_wr_en", 32'(o_wr_en), 32'(we));
    check("alu_opload", 32'(o_opcode_load), 32'd0);
    check("alu_req", 32'(bus.o_req), 32'd0);
    next_cycle();
    check("alu_ce_drop", 32'(o_ce), 32'd0);
  endtask

  task automatic do_mem(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdat,
                        input logic [4:0] rda, input logic we, input logic [31:0] rdv,
                        input int dly);
    i_ce = 1'b1; i_opcode_load = ld; i_opcode_store = !ld;
    i_funct3 = f3; i_addr = a; i_store_data = sd;
    i_rd_addr = rda; i_wr_en = we; i_rd = rdv;
    #1;
    if (ref_trap(f3, a)) begin
      check("trap_stall", 32'(o_stall), 32'd0);
      next_cycle();
      idle_inputs();
      check("trap_ce", 32'(o_ce), 32'd1);
      check("trap_mis", 32'(o_misaligned), 32'd1);
      check("trap_wr_en", 32'(o_wr_en), 32'd0);
      check("trap_req", 32'(bus.o_req), 32'd0);
      next_cycle();
      check("trap_ce_drop", 32'(o_ce), 32'd0);
      check("trap_req2", 32'(bus.o_req), 32'd0);
      return;
    end
    check("acc_stall", 32'(o_stall), 32'd1);
    next_cycle();
    // Upstream noise while waiting must be ignored.
    i_ce = 1'($urandom); i_opcode_load = 1'($urandom); i_opcode_store = 1'($urandom);
    i_funct3 = 3'($urandom); i_addr = $urandom; i_store_data = $urandom;
    i_rd_addr = 5'($urandom); i_wr_en = 1'($urandom); i_rd = $urandom;
    for (int k = 0; k <= dly; k++) begin
      bus.i_ack = (k == dly);
      bus.i_rdata = (k == dly) ? rdat : $urandom;
      #1;
      check("wait_req", 32'(bus.o_req), 32'd1);
      check("wait_addr", bus.o_addr, a & 32'hFFFF_FFFC);
      check("wait_we", 32'(bus.o_we), 32'(!ld));
      if (!ld) begin
        check("wait_be", 32'(bus.o_be), 32'(ref_be(f3, a)));
        check("wait_wdata", bus.o_wdata, ref_wdata(f3, sd));
      end
      check("wait_stall", 32'(o_stall), 32'(k != dly));
      if (k != dly) check("wait_no_ce", 32'(o_ce), 32'd0);
      next_cycle();
    end
    bus.i_ack = 1'b0;
    idle_inputs();
    check("done_ce", 32'(o_ce), 32'd1);
    check("done_req", 32'(bus.o_req), 32'd0);
    check("done_opload", 32'(o_opcode_load), 32'(ld));
    check("done_wr_en", 32'(o_wr_en), ld ? 32'(we) : 32'd0);
    check("done_rd_addr", 32'(o_rd_addr), 32'(rda));
    check("done_mis", 32'(o_misaligned), 32'd0);
    if (ld) check("done_loaded", o_mem_loaded, ref_load(f3, a, rdat));
    next_cycle();
    check("done_ce_drop", 32'(o_ce), 32'd0);
    check("done_wr_drop", 32'(o_wr_en), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ce"}, 32'(o_ce), 32'd0);
    check({tag, "_req"}, 32'(bus.o_req), 32'd0);
    check({tag, "_addr"}, bus.o_addr, 32'd0);
    check({tag, "_wdata"}, bus.o_wdata, 32'd0);
    check({tag, "_be"}, 32'(bus.o_be), 32'd0);
    check({tag, "_we"}, 32'(bus.o_we), 32'd0);
    check({tag, "_rd"}, o_rd, 32'd0);
    check({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
    check({tag, "_loaded"}, o_mem_loaded, 32'd0);
    check({tag, "_opload"}, 32'(o_opcode_load), 32'd0);
    check({tag, "_mis"}, 32'(o_misaligned), 32'd0);
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    int sel;
    n_vec = 0; n_err = 0;
    i_rst_n = 1'b0;
    i_ce = 1'b1; i_opcode_load = 1'b1; i_opcode_store = 1'b0;
    i_funct3 = 3'd2; i_addr = 32'h40; i_store_data = 32'd0;
    i_rd_addr = 5'd0; i_wr_en = 1'b0; i_rd = 32'd0;
    bus.i_ack = 1'b0; bus.i_rdata = 32'd0;
    next_cycle();
    next_cycle();
    check("rst_stall", 32'(o_stall), 32'd0);
    check_all_zero("rst");
    idle_inputs();
    i_rst_n = 1'b1;
    next_cycle();

    do_alu(5'd5, 1'b1, 32'h0000_1234);
    do_mem(1'b1, 3'd0, 32'h103, 32'd0, 32'h80FF_FFFF, 5'd7, 1'b1, 32'd0, 0);
    do_mem(1'b0, 3'd1, 32'h202, 32'hABCD_1234, 32'd0, 5'd3, 1'b1, 32'd0, 3);

    // An ack while idle must not produce a completion.
    bus.i_ack = 1'b1;
    next_cycle();
    bus.i_ack = 1'b0;
    check("idle_ack_ce", 32'(o_ce), 32'd0);
    check("idle_ack_req", 32'(bus.o_req), 32'd0);

    // Reset in the middle of an outstanding LW, then a late ack.
    i_ce = 1'b1; i_opcode_load = 1'b1; i_opcode_store = 1'b0;
    i_funct3 = 3'd2; i_addr = 32'h500; i_rd_addr = 5'd9; i_wr_en = 1'b1;
    next_cycle();
    idle_inputs();
    check("abort_req", 32'(bus.o_req), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("abort_stall", 32'(o_stall), 32'd0);
    next_cycle();
    check_all_zero("abort");
    i_rst_n = 1'b1;
    bus.i_ack = 1'b1; bus.i_rdata = 32'hDEAD_BEEF;
    next_cycle();
    bus.i_ack = 1'b0;
    check("late_ack_ce", 32'(o_ce), 32'd0);
    check("late_ack_req", 32'(bus.o_req), 32'd0);
    next_cycle();
    check("late_ack_ce2", 32'(o_ce), 32'd0);

`ifdef MISALIGN_TRAP_EN
    do_mem(1'b1, 3'd2, 32'h301, 32'd0, 32'd0, 5'd4, 1'b1, 32'd0, 0);
`endif

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 2);
      a = $urandom;
      if (sel == 0) begin
        do_alu(5'($urandom), 1'($urandom), $urandom);
      end else if (sel == 1) begin
        f3 = 3'($urandom);
        do_mem(1'b1, f3, a, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
               $urandom_range(0, 3));
      end else begin
        f3 = 3'($urandom_range(0, 2));
        do_mem(1'b0, f3, a, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
               $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
